fft_agu: RTL and testbench

Address generation unit for the in-place radix-2 DIT FFT datapath. The block drives both ports of the dual-port FFT RAM with butterfly operand addresses and write enables, and the BFU with twiddle indices, for every stage of an N-point transform. For each butterfly it runs a read, then a BFU-latency wait, then a write-back to the same two addresses. Input data is already in bit-reversed order when `start` arrives.

---
 rtl/fft_agu.sv | 116 +++++++++++
 tb/tb_fft_agu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fft_agu.sv
// Address generation unit for an in-place radix-2 DIT FFT: sequences READ/WAIT/WRITE
// per butterfly and decodes dual-port RAM addresses and twiddle indices from (stage, k).
module fft_agu #(
  parameter int N_LOG2  = 5,
  parameter int ADDR_W  = 8,
  parameter int BFU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              wr_a,
  output logic              wr_b,
  output logic              q_valid,
  output logic [N_LOG2-2:0] tw_addr
);

  localparam int KW = N_LOG2 - 1;
  localparam int SW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [SW-1:0] S_LAST   = SW'(N_LOG2 - 1);
  localparam logic [2:0]    CNT_INIT = 3'((BFU_LAT > 0) ? BFU_LAT - 1 : 0);

  logic [2:0]    r_state;
  logic [SW-1:0] r_s;
  logic [KW-1:0] r_k;
  logic [2:0]    r_cnt;
  logic          r_qv;

  logic [KW-1:0]     w_mask;
  logic [KW-1:0]     w_pos;
  logic [N_LOG2-1:0] w_grp;
  logic [N_LOG2-1:0] w_i;
  logic [N_LOG2-1:0] w_j;
  logic [KW-1:0]     w_tw;
  logic              w_act;

  // pos = k mod 2^s, group = k >> s; i interleaves group above bit s, j sets bit s
  assign w_mask = ~({KW{1'b1}} << r_s);
  assign w_pos  = r_k & w_mask;
  assign w_grp  = {1'b0, (r_k >> r_s)};
  assign w_i    = (w_grp << ({1'b0, r_s} + 1'b1)) | {1'b0, w_pos};
  assign w_j    = w_i | (N_LOG2'(1) << r_s);
  assign w_tw   = w_pos << (SW'(KW) - r_s);

  assign w_act   = (r_state == S_READ) || (r_state == S_WAIT) || (r_state == S_WRITE);
  assign busy    = w_act;
  assign done    = (r_state == S_DONE);
  assign wr_a    = (r_state == S_WRITE);
  assign wr_b    = (r_state == S_WRITE);
  assign q_valid = r_qv;
  assign addr_a  = w_act ? ADDR_W'(w_i) : '0;
  assign addr_b  = w_act ? ADDR_W'(w_j) : '0;
  assign tw_addr = w_act ? w_tw : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_qv    <= 1'b0;
    end else begin
      // RAM q lands one cycle after the READ address is presented
      r_qv <= (r_state == S_READ);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_READ;
            r_s     <= '0;
            r_k     <= '0;
          end
        end
        S_READ: begin
          if (BFU_LAT > 0) begin
            r_state <= S_WAIT;
            r_cnt   <= CNT_INIT;
          end else begin
            r_state <= S_WRITE;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) r_state <= S_WRITE;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_WRITE: begin
          if (&r_k) begin
            r_k <= '0;
            if (r_s == S_LAST) begin
              r_s     <= '0;
              r_state <= S_DONE;
            end else begin
              r_s     <= r_s + 1'b1;
              r_state <= S_READ;
            end
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= S_READ;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_agu.sv
// Directed bench for fft_agu at default parameters (N=32, BFU_LAT=1).
module tb_fft_agu;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, wr_a, wr_b, q_valid;
  logic [7:0] addr_a, addr_b;
  logic [3:0] tw_addr;

  int n_chk  = 0;
  int n_fail = 0;
  int n_busy = 0;

  fft_agu #(.N_LOG2(5), .ADDR_W(8), .BFU_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .addr_a(addr_a), .addr_b(addr_b), .wr_a(wr_a), .wr_b(wr_b),
    .q_valid(q_valid), .tw_addr(tw_addr)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (busy) n_busy++;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_busy"},    32'(busy),    0);
    chk({tag, "_done"},    32'(done),    0);
    chk({tag, "_wr_a"},    32'(wr_a),    0);
    chk({tag, "_wr_b"},    32'(wr_b),    0);
    chk({tag, "_q_valid"}, 32'(q_valid), 0);
    chk({tag, "_addr_a"},  32'(addr_a),  0);
    chk({tag, "_addr_b"},  32'(addr_b),  0);
    chk({tag, "_tw"},      32'(tw_addr), 0);
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entered in the first READ cycle; walks every butterfly of all five stages.
  task automatic run_full(input bit inject);
    int half, pos, grp, ei, ej, etw;
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < 16; k++) begin
        half = 1 << s;
        pos  = k % half;
        grp  = k / half;
        ei   = grp * 2 * half + pos;
        ej   = ei + half;
        etw  = pos * (16 / half);
        chk("rd_busy", 32'(busy),    1);
        chk("rd_a",    32'(addr_a),  32'(ei));
        chk("rd_b",    32'(addr_b),  32'(ej));
        chk("rd_tw",   32'(tw_addr), 32'(etw));
        chk("rd_wr_a", 32'(wr_a),    0);
        chk("rd_wr_b", 32'(wr_b),    0);
        chk("rd_qv",   32'(q_valid), 0);
        chk("rd_done", 32'(done),    0);
        if (s == 1 && k == 1) begin
          chk("s1k1_a", 32'(addr_a), 1);
          chk("s1k1_b", 32'(addr_b), 3);
          chk("s1k1_tw", 32'(tw_addr), 8);
        end
        if (s == 4 && k == 5) begin
          chk("s4k5_a", 32'(addr_a), 5);
          chk("s4k5_b", 32'(addr_b), 21);
          chk("s4k5_tw", 32'(tw_addr), 5);
        end
        if (inject && s == 2 && k == 3) start = 1'b1;
        step();
        start = 1'b0;
        chk("wt_a",    32'(addr_a),  32'(ei));
        chk("wt_b",    32'(addr_b),  32'(ej));
        chk("wt_tw",   32'(tw_addr), 32'(etw));
        chk("wt_wr_a", 32'(wr_a),    0);
        chk("wt_qv",   32'(q_valid), 1);
        chk("wt_busy", 32'(busy),    1);
        step();
        chk("wr_a_addr", 32'(addr_a),  32'(ei));
        chk("wr_b_addr", 32'(addr_b),  32'(ej));
        chk("wr_tw",     32'(tw_addr), 32'(etw));
        chk("wr_wr_a",   32'(wr_a),    1);
        chk("wr_wr_b",   32'(wr_b),    1);
        chk("wr_qv",     32'(q_valid), 0);
        chk("wr_busy",   32'(busy),    1);
        step();
      end
    end
    chk("end_done",   32'(done),   1);
    chk("end_busy",   32'(busy),   0);
    chk("end_addr_a", 32'(addr_a), 0);
    chk("end_wr",     32'(wr_a),   0);
    chk("busy_cycles", 32'(n_busy), 240);
    step();
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 idle_outs("reset_noclk");
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) begin
      step();
      idle_outs("idle");
    end

    n_busy = 0;
    start_pulse();
    run_full(1'b0);

    n_busy = 0;
    start_pulse();
    run_full(1'b1);

    start_pulse();
    repeat (96) step();
    chk("mid_busy",   32'(busy),   1);
    chk("mid_addr_a", 32'(addr_a), 0);
    chk("mid_addr_b", 32'(addr_b), 4);
    #2 rst = 1'b1;
    #1 idle_outs("async_rst");
    @(negedge clk) rst = 1'b0;
    step();
    idle_outs("post_rst");
    n_busy = 0;
    start_pulse();
    run_full(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
